cipher_seq: RTL and testbench
=============================

CIPHER_SEQ -- requirements
Module: cipher_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  request present.
REQ-004 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-005 in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-006 in_data  input  256  encrypt: bits[247:0] plaintext, bits[255:248] ignored; decrypt: full ciphertext.
REQ-007 in_key  input  64  key; L = in_key[63:32], R = in_key[31:0].
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_data  output  256  result.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The request is accepted on a rising edge with in_valid & in_ready; in_mode, in_data and in_key are captured then, and later input changes are ignored.
REQ-013 The key schedule is k1 = zero-extended 33-bit (L + R) to 64 bits, and k2 = (zext64(L) - zext64(R)) mod 2^64.
REQ-014 Encrypt operands:
- pad = {8'd248, in_data[247:0]}.
- P1..P4 = pad[255:192], [191:128], [127:64], [63:0].
- Each Pi is rotated right by 1.
REQ-015 Encrypt XOR and output:
- Ei = rotr(Pi) ^ k2 for i = 1..3.
- E4 = rotr(P4) ^ k1 ^ k2.
- out_data = {E4, E1, E2, E3}.
REQ-016 Decrypt operands: C1..C4 = in_data[255:192], [191:128], [127:64], [63:0].
REQ-017 Decrypt XOR and output:
- D1 = rotl(C1 ^ k1 ^ k2).
- Di = rotl(Ci ^ k2) for i = 2..4.
- rotl is a 64-bit rotate left by 1.
- out_data = {D2, D3, D4, D1}.
REQ-018 The datapath is lane-serial: one shared 64-bit XOR/rotate unit processes lane index 0..3, one lane per cycle, and a 2-bit lane counter wraps 3 -> 0 on exit.
REQ-019 The FSM states are IDLE, KEYGEN, LANE, DONE.
REQ-020 FSM transitions:
- IDLE -> KEYGEN on accept.
- KEYGEN -> LANE after 1 cycle, with k1 and k2 registered.
- LANE -> DONE after lane 3.
- DONE -> IDLE when out_valid & out_ready.
REQ-021 Latency: out_valid rises 5 rising edges after the accept edge (KEYGEN 1 cycle plus 4 lane cycles).
REQ-022 out_valid is high only in DONE, and out_data is held stable while out_valid = 1 and out_ready = 0.
REQ-023 in_valid is ignored while busy = 1; no queuing takes place.
REQ-024 in_ready is low in DONE, even in the cycle the result is taken; the next accept is possible at the earliest one cycle after the DONE -> IDLE transition.

Reset
REQ-025 rst_n = 0 forces state = IDLE, lane counter = 0, out_valid = 0, out_data = 0, busy = 0, k1 = k2 = 0, in_ready = 1 once rst_n = 1.
REQ-026 Reset mid-operation discards the in-flight request with no partial result and no out_valid pulse.

Configuration
REQ-027 With CIPHER_SEQ_KEYCACHE_EN defined, the block keeps the last captured in_key plus a cache-valid flag.
REQ-028 With CIPHER_SEQ_KEYCACHE_EN defined, an accept whose key equals the cached key with the flag set goes IDLE -> LANE directly (latency 4); otherwise it goes through KEYGEN.
REQ-029 With CIPHER_SEQ_KEYCACHE_EN defined, reset clears the cache-valid flag.
REQ-030 Without CIPHER_SEQ_KEYCACHE_EN, every request passes through KEYGEN and the latency is always 5.

Verification
REQ-031 Reset check: assert rst_n = 0 mid-LANE -> the next cycle shows out_valid = 0, busy = 0, out_data = 0; after release, in_ready = 1.
REQ-032 Encrypt vector: mode = 0, in_data = 20, in_key = 15 (k1 = 0xF, k2 = 0xFFFFFFFFFFFFFFF1) -> out_data = FFFFFFFFFFFFFFF4_83FFFFFFFFFFFFF1_FFFFFFFFFFFFFFF1_FFFFFFFFFFFFFFF1, out_valid 5 edges after accept.
REQ-033 Decrypt round trip: feed the REQ-032 result with mode = 1 and key = 15 -> out_data = F800000000000000_0000000000000000_0000000000000000_0000000000000014.
REQ-034 Backpressure: hold out_ready = 0 for 3 cycles in DONE and pulse in_valid -> out_data stable, in_ready = 0, no second accept; out_ready = 1 -> IDLE next cycle.
REQ-035 Key cache, with CIPHER_SEQ_KEYCACHE_EN: two back-to-back encrypts with key 15 -> latency 5 then 4; a third with key 16 -> latency 5; without the macro all three have latency 5.

Source files
------------

// File: rtl/cipher_seq.sv
// Lane-serial 256-bit XOR/rotate cipher: key schedule, then one 64-bit lane per cycle.
// Optional key cache (skips KEYGEN on a repeated key) enabled by CIPHER_SEQ_KEYCACHE_EN.
module cipher_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [255:0] in_data,
    input  logic [63:0]  in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and out_data holds until taken.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYGEN = 2'd1,
        LANE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     lane_q, lane_d;
    logic           mode_q, mode_d;
    logic [255:0]   data_q, data_d;
    logic [63:0]    key_q, key_d;
    logic [63:0]    k1_q, k1_d;
    logic [63:0]    k2_q, k2_d;
    logic [255:0]   res_q, res_d;

    logic           accept;
    logic           cache_hit;
    logic [63:0]    op;
    logic [63:0]    mask;
    logic [63:0]    pre;
    logic [63:0]    lane_res;
    logic [1:0]     slot;
    logic           extra_k1;

    assign accept = in_valid && (state_q == IDLE);

`ifdef CIPHER_SEQ_KEYCACHE_EN
    logic cache_vld_q, cache_vld_d;

    // key_q doubles as the cached key; k1/k2 still hold its schedule.
    assign cache_vld_d = cache_vld_q | accept;
    assign cache_hit   = cache_vld_q && (in_key == key_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cache_vld_q <= 1'b0;
        else        cache_vld_q <= cache_vld_d;
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Shared lane unit: encrypt rotates then XORs, decrypt XORs then rotates.
    assign op       = data_q[{~lane_q, 6'b0} +: 64];
    assign extra_k1 = mode_q ? (lane_q == 2'd0) : (lane_q == 2'd3);
    assign mask     = k2_q ^ (extra_k1 ? k1_q : 64'd0);
    assign pre      = op ^ mask;
    assign lane_res = mode_q ? {pre[62:0], pre[63]} : ({op[0], op[63:1]} ^ mask);
    // Output slot counted from the top word; encrypt shifts lanes down one, decrypt up one.
    assign slot     = mode_q ? (lane_q + 2'd3) : (lane_q + 2'd1);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        mode_d  = mode_q;
        data_d  = data_q;
        key_d   = key_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = in_mode;
                    data_d  = in_mode ? in_data : {8'd248, in_data[247:0]};
                    key_d   = in_key;
                    lane_d  = 2'd0;
                    state_d = cache_hit ? LANE : KEYGEN;
                end
            end
            KEYGEN: begin
                k1_d    = {31'd0, {1'b0, key_q[63:32]} + {1'b0, key_q[31:0]}};
                k2_d    = {32'd0, key_q[63:32]} - {32'd0, key_q[31:0]};
                state_d = LANE;
            end
            LANE: begin
                res_d[{~slot, 6'b0} +: 64] = lane_res;
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            key_q   <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            key_q   <= key_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            res_q   <= res_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_data    = res_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cipher_seq.sv
// Bench for cipher_seq: directed vectors, backpressure, key cache latency, random traffic, reset abort.
module tb_cipher_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [255:0] in_data;
    logic [63:0]  in_key;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         busy;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [255:0] exp_q[$];
    logic [63:0]  cache_key;
    bit           cache_ok;

`ifdef CIPHER_SEQ_KEYCACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    cipher_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [63:0] rotr1(input logic [63:0] x);
        return (x >> 1) | (x << 63);
    endfunction

    function automatic logic [63:0] rotl1(input logic [63:0] x);
        return (x << 1) | (x >> 63);
    endfunction

    function automatic logic [255:0] m_enc(input logic [255:0] d, input logic [63:0] key);
        logic [63:0]  k1, k2;
        logic [63:0]  e[4];
        logic [255:0] pad;
        k1  = 64'(key[63:32]) + 64'(key[31:0]);
        k2  = 64'(key[63:32]) - 64'(key[31:0]);
        pad = {8'd248, d[247:0]};
        for (int i = 0; i < 4; i++) e[i] = rotr1(pad[255 - 64*i -: 64]) ^ k2;
        e[3] = e[3] ^ k1;
        return {e[3], e[0], e[1], e[2]};
    endfunction

    function automatic logic [255:0] m_dec(input logic [255:0] d, input logic [63:0] key);
        logic [63:0] k1, k2, x;
        logic [63:0] r[4];
        k1 = 64'(key[63:32]) + 64'(key[31:0]);
        k2 = 64'(key[63:32]) - 64'(key[31:0]);
        for (int i = 0; i < 4; i++) begin
            x    = d[255 - 64*i -: 64] ^ k2 ^ ((i == 0) ? k1 : 64'd0);
            r[i] = rotl1(x);
        end
        return {r[1], r[2], r[3], r[0]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // scoreboard comparison
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks (all start and end at #1 after a rising edge)
    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cache_ok = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_req(input logic mode, input logic [255:0] data, input logic [63:0] key,
                           input int hold, output logic [255:0] result);
        int           exp_lat;
        int           lat;
        logic [255:0] held;
        exp_lat  = (CACHE && cache_ok && key == cache_key) ? 4 : 5;
        cache_key = key;
        cache_ok  = 1'b1;
        exp_q.push_back(mode ? m_dec(data, key) : m_enc(data, key));
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_key   = key;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand256();
        in_key   = {$urandom(), $urandom()};
        in_mode  = 1'($urandom_range(0, 1));
        check("busy_after_accept", busy, 1);
        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("latency", lat, exp_lat);
        if (!out_valid) begin
            result = '0;
            apply_reset();
            return;
        end
        result = out_data;
        check("out_data", out_data, exp_q.pop_front());
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_data", out_data, held);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("taken_valid", out_valid, 0);
        check("taken_in_ready", in_ready, 1);
        check("taken_busy", busy, 0);
    endtask

    // stimulus
    initial begin
        logic [255:0] r1, r2, d;
        logic [63:0]  k;
        logic         m;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        cache_ok  = 1'b0;
        cache_key = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // directed encrypt vector with 3-cycle backpressure, then decrypt round trip
        run_req(1'b0, 256'd20, 64'd15, 3, r1);
        check("enc_vector", r1,
              256'hFFFFFFFFFFFFFFF4_83FFFFFFFFFFFFF1_FFFFFFFFFFFFFFF1_FFFFFFFFFFFFFFF1);
        run_req(1'b1, r1, 64'd15, 0, r2);
        check("dec_vector", r2,
              256'hF800000000000000_0000000000000000_0000000000000000_0000000000000014);

        // key cache sequence from a fresh reset: 15, 15, 16
        apply_reset();
        run_req(1'b0, rand256(), 64'd15, 0, r1);
        run_req(1'b0, rand256(), 64'd15, 1, r1);
        run_req(1'b0, rand256(), 64'd16, 0, r1);

        // random traffic with encrypt/decrypt round trips
        for (int n = 0; n < 24; n++) begin
            d = rand256();
            case ($urandom_range(0, 2))
                0:       k = 64'd15;
                1:       k = {32'hDEADBEEF, 32'h12345678};
                default: k = {$urandom(), $urandom()};
            endcase
            m = 1'($urandom_range(0, 1));
            run_req(m, d, k, int'($urandom_range(0, 2)), r1);
            if (!m) begin
                run_req(1'b1, r1, k, 0, r2);
                check("round_trip", r2, {8'd248, d[247:0]});
            end
        end

        // reset in the middle of LANE discards the request
        check("pre_abort_ready", in_ready, 1);
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = rand256();
        in_key   = 64'd99;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_in_lane", dbg_state, 2);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        check("abort_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cache_ok = 1'b0;
        check("abort_in_ready", in_ready, 1);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("abort_no_pulse", out_valid, 0);
        end

        // recovery after abort; the cache was cleared so the same key goes through KEYGEN
        run_req(1'b0, 256'd20, 64'd99, 0, r1);
        run_req(1'b1, r1, 64'd99, 0, r2);
        check("recover_round_trip", r2, {8'd248, 248'd20});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
